// File: rtl/w_ram_line_loader.sv
// Packs a narrow valid/ready word stream into wide RAM lines, one single-cycle
// write per line, from a programmable base address with wrap at DATA_DEPTH-1.
module w_ram_line_loader #(
    parameter int DATA_WIDTH = 4608,
    parameter int DATA_DEPTH = 1024,
    parameter int WORD_WIDTH = 32,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   num_lines_i,
    input  logic [WORD_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int N_WORD    = DATA_WIDTH / WORD_WIDTH;
    localparam int CNT_WIDTH = $clog2(N_WORD);
    localparam int LW        = ADDR_WIDTH + 1;
    localparam int PW        = DATA_WIDTH - WORD_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q;
    logic [LW-1:0]         line_cnt_q;
    logic [LW-1:0]         num_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [PW-1:0]         part_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  accept;
    logic                  last_word;

    assign accept    = s_ready_o & s_valid_i;
    assign last_word = (word_cnt_q == CNT_WIDTH'(N_WORD - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        s_ready_o = 1'b0;
        wr_en_o   = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = (num_lines_i == '0) ? S_DONE : S_FILL;
            end
            S_FILL: begin
                s_ready_o = 1'b1;
                busy_o    = 1'b1;
                if (s_valid_i && last_word) state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_en_o = 1'b1;
                busy_o  = 1'b1;
                state_d = (line_cnt_q + LW'(1) == num_q) ? S_DONE : S_FILL;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Words shift in at the LSB end so the first word of a line ends up in the MSBs;
    // the full line is frozen into wr_data_q on the last word so it holds between writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            num_q      <= '0;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            part_q     <= '0;
            wr_data_q  <= '0;
        end else begin
            if (state_q == S_IDLE && start_i) begin
                addr_q     <= base_addr_i;
                num_q      <= num_lines_i;
                line_cnt_q <= '0;
                word_cnt_q <= '0;
            end
            if (accept) begin
                part_q     <= PW'({part_q, s_data_i});
                word_cnt_q <= last_word ? '0 : word_cnt_q + CNT_WIDTH'(1);
                if (last_word) begin
                    wr_data_q <= {part_q, s_data_i};
                    wr_addr_q <= addr_q;
                end
            end
            if (state_q == S_WRITE) begin
                line_cnt_q <= line_cnt_q + LW'(1);
                addr_q     <= (addr_q == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule
